// File: rtl/enc_pkg.sv
// Shared constants and helpers for the request encoders/arbiters.
// Used by rr_pick and rr_encode_reg.
package enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Round-robin pointer advance. It wraps explicitly, so non-power-of-two N never leaves 0..N-1.
    function automatic int ptr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

    // True when more than one bit is set (clearing the lowest set bit leaves something).
    function automatic logic multi_hot(input logic [63:0] v);
        return (v & (v - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: lowest set request bit (fixed mode), or the first set bit
// at or above ptr with wrap-around (round-robin mode).
module rr_pick
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] req_hi;
    logic [W-1:0] idx_hi;
    logic [W-1:0] idx_lo;
    logic         found_hi;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign hi_mask[gi] = (ptr <= W'(gi));
        end
    endgenerate

    assign req_hi = req & hi_mask;
    assign any    = |req;

    // Scanning downward leaves the lowest set index in each candidate.
    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_lo = W'(i);
            end
            if (req_hi[i]) begin
                idx_hi   = W'(i);
                found_hi = 1'b1;
            end
        end
        idx = (mode == MODE_RR && found_hi) ? idx_hi : idx_lo;
    end

endmodule

// File: rtl/rr_encode_reg.sv
// Registered N-to-log2(N) encoder with fixed-priority or round-robin grant and a valid/ready output.
// RR_ENCODE_ONEHOT_OUT_EN adds a registered one-hot copy of the granted index (out_onehot).
module rr_encode_reg
    import enc_pkg::*;
#(
    parameter int   N    = 8,
    parameter int   W    = $clog2(N),
    parameter logic MODE = MODE_FIXED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic         out_multi
`ifdef RR_ENCODE_ONEHOT_OUT_EN
    ,
    output logic [N-1:0] out_onehot
`endif
);

    logic [W-1:0] ptr_reg;
    logic [W-1:0] pick_idx;
    logic         pick_any;
    logic         cap;

    rr_pick #(
        .N(N),
        .W(W)
    ) u_pick (
        .req (req),
        .ptr (ptr_reg),
        .mode(MODE),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A stalled result blocks capture, so req is ignored until the consumer takes it.
    assign cap = en & pick_any & (~out_valid | out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_multi  <= 1'b0;
            ptr_reg    <= '0;
`ifdef RR_ENCODE_ONEHOT_OUT_EN
            out_onehot <= '0;
`endif
        end else if (cap) begin
            out_valid  <= 1'b1;
            out_idx    <= pick_idx;
            out_multi  <= multi_hot(64'(req));
            if (MODE == MODE_RR) begin
                ptr_reg <= W'(ptr_next(int'(pick_idx), N));
            end
`ifdef RR_ENCODE_ONEHOT_OUT_EN
            out_onehot <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_encode_reg.sv
// Bench for rr_encode_reg: three instances (N=4 fixed, N=8 round-robin, N=5 round-robin)
// checked every cycle against a rotation-scan reference model, plus directed sequences.
module tb_rr_encode_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       en4, rdy4, v4, m4;
    logic [3:0] req4;
    logic [1:0] i4;
    logic       en8, rdy8, v8, m8;
    logic [7:0] req8;
    logic [2:0] i8;
    logic       en5, rdy5, v5, m5;
    logic [4:0] req5;
    logic [2:0] i5;
`ifdef RR_ENCODE_ONEHOT_OUT_EN
    logic [3:0] oh4;
    logic [7:0] oh8;
    logic [4:0] oh5;
`endif

    rr_encode_reg #(.N(4), .MODE(1'b0)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .req(req4), .out_ready(rdy4),
        .out_valid(v4), .out_idx(i4), .out_multi(m4)
`ifdef RR_ENCODE_ONEHOT_OUT_EN
        , .out_onehot(oh4)
`endif
    );

    rr_encode_reg #(.N(8), .MODE(1'b1)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .req(req8), .out_ready(rdy8),
        .out_valid(v8), .out_idx(i8), .out_multi(m8)
`ifdef RR_ENCODE_ONEHOT_OUT_EN
        , .out_onehot(oh8)
`endif
    );

    rr_encode_reg #(.N(5), .MODE(1'b1)) dut5 (
        .clk(clk), .rst(rst), .en(en5), .req(req5), .out_ready(rdy5),
        .out_valid(v5), .out_idx(i5), .out_multi(m5)
`ifdef RR_ENCODE_ONEHOT_OUT_EN
        , .out_onehot(oh5)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference state per instance: 0 = N4 fixed, 1 = N8 rr, 2 = N5 rr
    int          mv[3];
    int          mi[3];
    int          mm[3];
    int          mp[3];
    logic [63:0] moh[3];

    int tab4[5] = '{1, 2, 4, 8, 15};
    int exp4[5] = '{0, 1, 2, 3, 0};
    int exp8[5] = '{0, 2, 7, 0, 2};
    int exp5[5] = '{0, 4, 0, 4, 0};

    function automatic int pick(input logic [63:0] r, input int n, input int p);
        for (int k = 0; k < n; k++) begin
            int j;
            j = (p + k) % n;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            mv[d] = 0; mi[d] = 0; mm[d] = 0; mp[d] = 0; moh[d] = '0;
        end
    endtask

    task automatic model(input int d, input int n, input int rr, input logic e,
                         input logic [63:0] r, input logic rd);
        bit cap;
        int g;
        cap = e && (r != 0) && (mv[d] == 0 || rd);
        if (cap) begin
            g      = pick(r, n, rr ? mp[d] : 0);
            mv[d]  = 1;
            mi[d]  = g;
            mm[d]  = ($countones(r) > 1) ? 1 : 0;
            moh[d] = 64'd1 << g;
            if (rr != 0) mp[d] = (g + 1) % n;
        end else if (rd) begin
            mv[d] = 0;
        end
    endtask

    task automatic check_all();
        chk("n4 valid", 64'(v4), 64'(mv[0]));
        chk("n4 idx",   64'(i4), 64'(mi[0]));
        chk("n4 multi", 64'(m4), 64'(mm[0]));
        chk("n8 valid", 64'(v8), 64'(mv[1]));
        chk("n8 idx",   64'(i8), 64'(mi[1]));
        chk("n8 multi", 64'(m8), 64'(mm[1]));
        chk("n5 valid", 64'(v5), 64'(mv[2]));
        chk("n5 idx",   64'(i5), 64'(mi[2]));
        chk("n5 multi", 64'(m5), 64'(mm[2]));
`ifdef RR_ENCODE_ONEHOT_OUT_EN
        chk("n4 onehot", 64'(oh4), moh[0]);
        chk("n8 onehot", 64'(oh8), moh[1]);
        chk("n5 onehot", 64'(oh5), moh[2]);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model(0, 4, 0, en4, 64'(req4), rdy4);
        model(1, 8, 1, en8, 64'(req8), rdy8);
        model(2, 5, 1, en5, 64'(req5), rdy5);
        check_all();
        $display("[TB] t=%0t n4 v=%0d i=%0d m=%0d | n8 v=%0d i=%0d m=%0d | n5 v=%0d i=%0d m=%0d",
                 $time, v4, i4, m4, v8, i8, m8, v5, i5, m5);
    endtask

    initial begin
        en4 = 0; en8 = 0; en5 = 0;
        rdy4 = 0; rdy8 = 0; rdy5 = 0;
        req4 = '0; req8 = '0; req5 = '0;
        model_reset();

        // Reset state while rst is held
        @(posedge clk);
        #1;
        check_all();
        #3 rst = 1'b0;

        // Legacy mapping (N=4 fixed), round-robin on N=8 and N=5 in parallel
        en4 = 1; en8 = 1; en5 = 1;
        rdy4 = 1; rdy8 = 1; rdy5 = 1;
        req8 = 8'b1000_0101;
        req5 = 5'b10001;
        for (int s = 0; s < 5; s++) begin
            req4 = 4'(tab4[s]);
            tick();
            chk("n4 seq idx",   64'(i4), 64'(exp4[s]));
            chk("n4 seq multi", 64'(m4), (s == 4) ? 64'd1 : 64'd0);
            chk("n8 seq idx",   64'(i8), 64'(exp8[s]));
            chk("n5 seq idx",   64'(i5), 64'(exp5[s]));
        end

        // Stall on N=8: held result ignores req changes until ready returns
        en4 = 0; en5 = 0;
        req8 = 8'h10;
        tick();
        chk("stall first idx", 64'(i8), 64'd4);
        rdy8 = 0;
        req8 = 8'h01;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall hold idx",   64'(i8), 64'd4);
            chk("stall hold valid", 64'(v8), 64'd1);
        end
        rdy8 = 1;
        tick();
        chk("stall release idx", 64'(i8), 64'd0);

        // Asynchronous reset in the middle of a cycle while a result is pending
        #2 rst = 1'b1;
        #1;
        chk("async rst valid", 64'(v8), 64'd0);
        chk("async rst idx",   64'(i8), 64'd0);
        chk("async rst multi", 64'(m8), 64'd0);
        model_reset();
        check_all();
        #2 rst = 1'b0;

        // en=0 blocks capture; req=0 with en=1 is a no-op
        en4 = 0; en8 = 0; en5 = 0;
        req4 = '1; req8 = '1; req5 = '1;
        for (int s = 0; s < 2; s++) begin
            tick();
            chk("en0 valid", 64'(v8), 64'd0);
        end
        en4 = 1; en8 = 1; en5 = 1;
        req4 = '0; req8 = '0; req5 = '0;
        for (int s = 0; s < 2; s++) begin
            tick();
            chk("req0 valid", 64'(v8), 64'd0);
        end

        // Randomised traffic with stalls and enable gaps
        for (int s = 0; s < 400; s++) begin
            en4  = ($urandom_range(0, 7) != 0);
            en8  = ($urandom_range(0, 7) != 0);
            en5  = ($urandom_range(0, 7) != 0);
            rdy4 = ($urandom_range(0, 3) != 0);
            rdy8 = ($urandom_range(0, 3) != 0);
            rdy5 = ($urandom_range(0, 3) != 0);
            req4 = 4'($urandom & $urandom);
            req8 = 8'($urandom & $urandom);
            req5 = 5'($urandom & $urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
